// File: rtl/mac_pkg.sv
// Shared constants and helpers for the MAC chain: weight format and the
// width of the exact multiply-add sum.
package mac_pkg;

    localparam int WEIGHT_WIDTH = 8;

    typedef logic [WEIGHT_WIDTH-1:0] weight_t;

    // Exact width of add + data*weight: product width plus one carry bit.
    function automatic int sum_width(input int data_width);
        return data_width + WEIGHT_WIDTH + 1;
    endfunction

endpackage

// File: rtl/mac_result_clip.sv
// Reduces the exact multiply-add sum to DATA_WIDTH bits and flags overflow.
// Wraps by default; saturates to all ones when MAC_SATURATE_EN is defined.
module mac_result_clip #(
    parameter int DATA_WIDTH = 32,
    parameter int SUM_WIDTH  = 41
) (
    input  logic [SUM_WIDTH-1:0]  wide_sum,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        overflow = |wide_sum[SUM_WIDTH-1:DATA_WIDTH];
        result   = wide_sum[DATA_WIDTH-1:0];
`ifdef MAC_SATURATE_EN
        if (overflow) begin
            result = '1;
        end
`endif
    end

endmodule

// File: rtl/multiply_add_stage.sv
// Registered multiply-accumulate stage: output_value <= add_value + input_value*weight_value.
// Define MAC_SATURATE_EN to clamp overflowing sums to all ones instead of wrapping.
module multiply_add_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int WEIGHT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   add_value,
    input  logic [DATA_WIDTH-1:0]   input_value,
    input  logic [WEIGHT_WIDTH-1:0] weight_value,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   output_value,
    output logic                    overflow
);

    import mac_pkg::*;

    localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int SUM_W  = sum_width(DATA_WIDTH);

    logic [PROD_W-1:0]     product;
    logic [SUM_W-1:0]      wide_sum;
    logic [DATA_WIDTH-1:0] clip_result;
    logic                  clip_ovf;

    // Operands are zero-extended before the multiply so nothing is lost.
    assign product  = PROD_W'(input_value) * PROD_W'(weight_value);
    assign wide_sum = SUM_W'(product) + SUM_W'(add_value);

    mac_result_clip #(
        .DATA_WIDTH (DATA_WIDTH),
        .SUM_WIDTH  (SUM_W)
    ) u_clip (
        .wide_sum (wide_sum),
        .result   (clip_result),
        .overflow (clip_ovf)
    );

    // Result and overflow only move on accepted operations; idle cycles hold them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            output_value <= '0;
            overflow     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            out_valid <= in_valid;
            if (in_valid) begin
                output_value <= clip_result;
                overflow     <= clip_ovf;
            end
        end
    end

endmodule

// File: tb/tb_multiply_add_stage.sv
// Scoreboard bench for multiply_add_stage (DATA_WIDTH=32): directed cases plus
// random traffic, checked against exact 64-bit arithmetic.
module tb_multiply_add_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] add_value;
    logic [31:0] input_value;
    logic [7:0]  weight_value;
    logic        out_valid;
    logic [31:0] output_value;
    logic        overflow;

    multiply_add_stage #(.DATA_WIDTH(32), .WEIGHT_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .add_value    (add_value),
        .input_value  (input_value),
        .weight_value (weight_value),
        .out_valid    (out_valid),
        .output_value (output_value),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    logic [31:0] last_data = '0;
    logic        last_ovf = 1'b0;

`ifdef MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact unsigned arithmetic in 64 bits, then wrap or clamp.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] i, input logic [7:0] w);
        exp_t e;
        longint unsigned exact;
        exact = longint'(a) + longint'(i) * longint'(w);
        e.ovf  = exact > 64'h0000_0000_FFFF_FFFF;
        e.data = (e.ovf && SAT) ? 32'hFFFF_FFFF : exact[31:0];
        e.due  = 0;
        return e;
    endfunction

    task automatic apply(input logic v, input logic [31:0] a, input logic [31:0] i, input logic [7:0] w);
        exp_t e;
        in_valid     = v;
        add_value    = a;
        input_value  = i;
        weight_value = w;
        if (v) begin
            e     = model(a, i, w);
            e.due = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] i, input logic [7:0] w);
        @(posedge clk);
        #1;
        apply(v, a, i, w);
    endtask

    // Monitor: one cycle after each accepted op a result must appear; otherwise outputs hold.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    check("missing_result", 64'(out_valid), 64'(1));
                    void'(sb.pop_front());
                end
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    check("out_valid", 64'(out_valid), 64'(1));
                    check("output_value", 64'(output_value), 64'(sb[0].data));
                    check("overflow", 64'(overflow), 64'(sb[0].ovf));
                    last_data = sb[0].data;
                    last_ovf  = sb[0].ovf;
                    void'(sb.pop_front());
                end else begin
                    check("idle_out_valid", 64'(out_valid), 64'(0));
                    check("idle_hold_value", 64'(output_value), 64'(last_data));
                    check("idle_hold_ovf", 64'(overflow), 64'(last_ovf));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        apply(1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_output_value", 64'(output_value), 64'(0));
        check("reset_overflow", 64'(overflow), 64'(0));
        rst_n = 1'b1;

        // Basic MAC, then idle hold with changing inputs.
        drive(1'b1, 32'd10, 32'd7, 8'd3);
        drive(1'b0, 32'd123, 32'd456, 8'd78);
        drive(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 8'hFF);
        drive(1'b0, 32'd1, 32'd2, 8'd3);

        // Streaming back-to-back.
        drive(1'b1, 32'd0, 32'd1, 8'd255);
        drive(1'b1, 32'd5, 32'd2, 8'd2);
        drive(1'b1, 32'd100, 32'd0, 8'd9);

        // Overflow and large products, weight/input zero boundaries.
        drive(1'b1, 32'hFFFF_FFFF, 32'd1, 8'd1);
        drive(1'b1, 32'd0, 32'h0100_0000, 8'hFF);
        drive(1'b1, 32'd0, 32'h0200_0000, 8'h80);
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hFF);
        drive(1'b1, 32'hCAFE_F00D, 32'hFFFF_FFFF, 8'd0);
        drive(1'b1, 32'hFFFF_FFFF, 32'd0, 8'hFF);
        drive(1'b0, 32'd9, 32'd9, 8'd9);
        drive(1'b0, 32'd9, 32'd9, 8'd9);

        // Reset mid-stream: outputs clear without a clock edge.
        drive(1'b1, 32'd1, 32'd1, 8'd1);
        drive(1'b1, 32'd2, 32'd2, 8'd2);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'(0));
        check("async_rst_output_value", 64'(output_value), 64'(0));
        check("async_rst_overflow", 64'(overflow), 64'(0));
        last_data = '0;
        last_ovf  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("held_rst_out_valid", 64'(out_valid), 64'(0));
        check("held_rst_output_value", 64'(output_value), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(1'b1, 32'd40, 32'd6, 8'd7);
        drive(1'b0, 32'd0, 32'd0, 8'd0);

        // Random traffic with occasional idles and extreme operands.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [31:0] i;
            logic [7:0]  w;
            a = $urandom();
            i = $urandom();
            w = 8'($urandom());
            case ($urandom_range(0, 5))
                0: a = 32'hFFFF_FFFF;
                1: i = 32'($urandom_range(0, 255));
                2: w = 8'd0;
                3: i = '0;
                default: ;
            endcase
            drive(($urandom_range(0, 3) != 0), a, i, w);
        end
        drive(1'b0, 32'd0, 32'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/multiply_add_stage.md
Name: multiply_add_stage

Overview:
- Registered multiply-accumulate stage: computes add_value + input_value × weight_value and registers the result.
- One instance per input lane in the weight-computation cell's MAC chain; instances cascade so each stage's output feeds the next stage's add_value.
- Weights are 8-bit unsigned constants; data operands are DATA_WIDTH unsigned.

Parameters:
- DATA_WIDTH, 32, width of add_value, input_value and output_value.
- WEIGHT_WIDTH, 8, width of weight_value; fixed at 8 in the current design.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle.
- add_value  input  DATA_WIDTH  accumulator input (partial sum from the previous stage).
- input_value  input  DATA_WIDTH  unsigned data operand.
- weight_value  input  WEIGHT_WIDTH  unsigned weight operand.
- out_valid  output  1  output_value was updated by the last valid cycle.
- output_value  output  DATA_WIDTH  registered add_value + input_value × weight_value.
- overflow  output  1  the exact sum of the last accepted operation did not fit in DATA_WIDTH bits.

Behaviour:
- Reset:
  - rst_n low asynchronously clears out_valid, output_value and overflow to 0.
  - Outputs stay 0 while rst_n is low.
  - The first capture occurs on the first rising clk edge after rst_n is released.
- Arithmetic:
  - Product: input_value × weight_value, computed exactly at DATA_WIDTH+WEIGHT_WIDTH bits.
  - Sum: product + add_value, computed at DATA_WIDTH+WEIGHT_WIDTH+1 bits.
  - All operands are unsigned.
  - Default result: the sum truncated to its low DATA_WIDTH bits (wrap modulo 2^DATA_WIDTH).
  - overflow = 1 when any bit of the sum above DATA_WIDTH-1 is set.
- Latency:
  - Exactly 1 clock.
  - On a rising edge with in_valid=1: output_value, overflow and out_valid=1 update from the current inputs.
- Idle:
  - On a rising edge with in_valid=0: out_valid goes 0.
  - output_value and overflow hold their previous values.
- Back-to-back: in_valid may be held high every cycle; each cycle's operands produce a result one cycle later, with no bubbles.
- No handshake back-pressure: the stage always accepts input.
- Reset mid-operation: an in-flight result is discarded; out_valid=0 immediately (asynchronously).
- Boundary cases:
  - weight_value=0 gives output_value=add_value with overflow=0.
  - input_value=0 gives the same result.

Optional Feature:
- Macro MAC_SATURATE_EN.
- Defined: when the sum exceeds 2^DATA_WIDTH−1, output_value = all ones (2^DATA_WIDTH−1) instead of wrapping. overflow is still asserted.
- Not defined: wrap-around truncation as specified above.
- Port list and latency are identical in both builds.

Decomposition:
- Shared package mac_pkg:
  - WEIGHT_WIDTH constant (8).
  - Typedef weight_t of WEIGHT_WIDTH bits.
  - Function returning the sum width, DATA_WIDTH+WEIGHT_WIDTH+1.
- One natural sub-module: mac_result_clip. It is purely combinational, takes the wide sum, and produces the DATA_WIDTH result plus the overflow bit. It is the only place MAC_SATURATE_EN is tested.
- The top level holds only the pipeline register and the valid register.

Test Plan (DATA_WIDTH=32):
- Reset: rst_n=0 mid-stream with in_valid=1 → out_valid, output_value and overflow become 0 immediately, without waiting for a clk edge; first result appears 1 cycle after release.
- Basic MAC: add=10, input=7, weight=3, in_valid=1 → next cycle output_value=31, out_valid=1, overflow=0.
- Streaming: three consecutive valid cycles (add=0, in=1, w=255), (add=5, in=2, w=2), (add=100, in=0, w=9) → outputs 255, 9, 100 on three consecutive cycles, out_valid continuously 1.
- Overflow wrap: add=32'hFFFF_FFFF, input=1, weight=1 → output_value=0, overflow=1. With MAC_SATURATE_EN: output_value=32'hFFFF_FFFF, overflow=1.
- Large product: add=0, input=32'h0100_0000, weight=8'hFF → wrap build: 32'hFF00_0000, overflow=0; then input=32'h0200_0000, weight=8'h80 → wrap build: 0, overflow=1; saturate build: 32'hFFFF_FFFF, overflow=1.
- Idle hold: valid op giving 31, then in_valid=0 for 3 cycles with changing inputs → out_valid=0, output_value stays 31, overflow stays 0.
